// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with integrated MEM/WB result register.
// Issues one data-memory request per load/store over a req/ready handshake.
// Holds the front of the pipeline while the access is outstanding.
// Handles byte/half/word lanes, sign extension, misalign faults and an optional bus timeout.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_addr_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_addr_out,
  output logic        wb_valid,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        we_q;
  logic        rd_op_q;
  logic [31:0] to_cnt;

  logic        mem_op;
  logic        fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        busy;
  logic        timeout_hit;

  assign mem_op = valid_in & (mem_read | mem_write);
  assign busy   = (state == BUSY);

  // Abort on the cycle that completes the TIMEOUT_CYCLES-th unanswered BUSY cycle;
  // a ready in that same cycle takes priority.
  assign timeout_hit = TO_EN && busy && !dmem_ready && (to_cnt == TO_LAST);

  // Decode lane enables, replicated store data and fault for the incoming access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fault      = 1'b0;
    be_next    = 4'b0000;
    wdata_next = rs2_data;
    case (funct3)
      F_B, F_BU: begin
        be_next    = 4'b0001 << alu_result[1:0];
        wdata_next = {4{rs2_data[7:0]}};
      end
      F_H, F_HU: begin
        be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{rs2_data[15:0]}};
        fault      = alu_result[0];
      end
      F_W: begin
        be_next = 4'b1111;
        fault   = |alu_result[1:0];
      end
      default: fault = 1'b1;
    endcase
  end

  // Extract and extend load data using the latched byte offset and size.
  always_comb begin
    ld_data = dmem_rdata;
    case (addr_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
      F_BU:    ld_data = {24'd0, ld_byte};
      F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
      F_HU:    ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Bus drive comes only from latched fields; stall is forced low while in reset.
  assign dmem_req   = busy;
  assign dmem_we    = busy & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = busy ? be_q : 4'b0000;
  assign stall      = rst_n && (busy ? (!dmem_ready && !timeout_hit)
                                     : (mem_op && !fault));

  // IDLE/BUSY control, access latches, timeout counter and MEM/WB result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      we_q        <= 1'b0;
      rd_op_q     <= 1'b0;
      to_cnt      <= '0;
      wb_data     <= '0;
      rd_addr_out <= '0;
      wb_valid    <= 1'b0;
      misaligned  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            wb_data     <= alu_result;
            rd_addr_out <= rd_addr_in;
            wb_valid    <= valid_in & reg_write_in;
          end else if (fault) begin
            misaligned <= 1'b1;
            wb_valid   <= 1'b0;
          end else begin
            addr_q   <= alu_result;
            wdata_q  <= wdata_next;
            be_q     <= be_next;
            f3_q     <= funct3;
            rd_q     <= rd_addr_in;
            rw_q     <= reg_write_in;
            we_q     <= mem_write;
            rd_op_q  <= mem_read;
            to_cnt   <= '0;
            wb_valid <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            state <= IDLE;
            if (rd_op_q) begin
              wb_data     <= ld_data;
              rd_addr_out <= rd_q;
              wb_valid    <= rw_q;
            end else begin
              wb_valid <= 1'b0;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            bus_error <= 1'b1;
            wb_valid  <= 1'b0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (timeout enabled, 4 cycles).
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_out;
  logic        wb_valid;
  logic        misaligned;
  logic        bus_error;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
    .rs2_data(rs2_data), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_data(wb_data), .rd_addr_out(rd_addr_out),
    .wb_valid(wb_valid), .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every writeback the DUT announces must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_wb", {31'd0, wb_valid}, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("sb_wb_data", wb_data, e.data);
        check("sb_wb_rd", {27'd0, rd_addr_out}, {27'd0, e.rd});
      end
    end
  end

  task automatic drop_inputs();
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic regw);
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = res; rd_addr_in = rd; reg_write_in = regw; funct3 = 3'b010;
    @(negedge clk);
    check("alu_stall", {31'd0, stall}, 32'd0);
    check("alu_req", {31'd0, dmem_req}, 32'd0);
    if (regw) sb.push_back('{data: res, rd: rd});
    @(posedge clk); #1;
    drop_inputs();
    @(negedge clk);
    check("alu_wb_valid", {31'd0, wb_valid}, {31'd0, regw});
  endtask

  task automatic run_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic regw, input int waits,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    bit timed_out = 1'b0;
    bit last      = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
    alu_result = addr; rs2_data = rs2; rd_addr_in = rd; reg_write_in = regw;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("op_idle_stall", {31'd0, stall}, 32'd1);
    check("op_idle_req", {31'd0, dmem_req}, 32'd0);
    for (int i = 0; i < TO; i++) begin
      @(posedge clk); #1;
      // Corrupt the held EX/MEM fields: BUSY must use its latched copy.
      alu_result = ~addr;
      rs2_data   = ~rs2;
      dmem_ready = (i == waits);
      dmem_rdata = dmem_ready ? rdata : 32'h0;
      timed_out  = !dmem_ready && (i == TO - 1);
      last       = dmem_ready || timed_out;
      @(negedge clk);
      check("busy_req", {31'd0, dmem_req}, 32'd1);
      check("busy_we", {31'd0, dmem_we}, {31'd0, wr_op});
      check("busy_addr", dmem_addr, {addr[31:2], 2'b00});
      check("busy_be", {28'd0, dmem_be}, {28'd0, exp_be});
      if (wr_op) check("busy_wdata", dmem_wdata, exp_wdata);
      check("busy_stall", {31'd0, stall}, {31'd0, !last});
      if (last) break;
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    drop_inputs();
    if (rd_op && regw && !timed_out) sb.push_back('{data: exp_wb, rd: rd});
    @(negedge clk);
    check("done_req", {31'd0, dmem_req}, 32'd0);
    check("done_bus_error", {31'd0, bus_error}, {31'd0, timed_out});
    check("done_misaligned", {31'd0, misaligned}, 32'd0);
    check("done_wb_valid", {31'd0, wb_valid}, {31'd0, rd_op && regw && !timed_out});
  endtask

  task automatic fault_op(input logic rd_op, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = rd_op; mem_write = !rd_op; funct3 = f3;
    alu_result = addr; rd_addr_in = 5'd11; reg_write_in = rd_op;
    @(negedge clk);
    check("flt_stall", {31'd0, stall}, 32'd0);
    check("flt_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    drop_inputs();
    @(negedge clk);
    check("flt_misaligned", {31'd0, misaligned}, 32'd1);
    check("flt_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("flt_bus_error", {31'd0, bus_error}, 32'd0);
    check("flt_req_after", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    check("flt_pulse_end", {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drop_inputs();
    alu_result = '0; rs2_data = '0; funct3 = '0; rd_addr_in = '0; reg_write_in = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #2;
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_pulses", {30'd0, misaligned, bus_error}, 32'd0);
    #20 rst_n = 1'b1;

    alu_op(32'h0000_1234, 5'd5, 1'b1);
    alu_op(32'h0000_CAFE, 5'd7, 1'b0);
    //     rd   wr   f3      addr          rs2           rd    rw  wait rdata          be       wdata          wb
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd3, 1'b1, 2, 32'h80FF_0000, 4'b1000, 32'h0,        32'hFFFF_FF80);
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd0, 1'b0, 0, 32'h0,        4'b1100, 32'h1234_1234, 32'h0);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd4, 1'b1, 1, 32'h80FF_0000, 4'b1000, 32'h0,        32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        5'd6, 1'b1, 0, 32'h8001_0000, 4'b1100, 32'h0,        32'hFFFF_8001);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,        5'd8, 1'b1, 0, 32'h0000_8001, 4'b0011, 32'h0,        32'h0000_8001);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,        5'd9, 1'b1, 3, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'h0,        5'd10, 1'b0, 0, 32'h1111_2222, 4'b1111, 32'h0,       32'h0);
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055, 5'd0, 1'b0, 1, 32'h0,        4'b0010, 32'h5555_5555, 32'h0);
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h1357_9BDF, 5'd0, 1'b0, 0, 32'h0,        4'b1111, 32'h1357_9BDF, 32'h0);

    fault_op(1'b1, 3'b010, 32'h0000_0101);
    fault_op(1'b1, 3'b001, 32'h0000_0003);
    fault_op(1'b1, 3'b011, 32'h0000_0000);
    fault_op(1'b0, 3'b010, 32'h0000_0002);

    // Ready never arrives: abort after TO unanswered BUSY cycles.
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd12, 1'b1, 99, 32'h0, 4'b1111, 32'h0, 32'h0);
    alu_op(32'h0000_0077, 5'd9, 1'b1);

    // Reset asserted while a load is outstanding.
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b101;
    alu_result = 32'h0000_0002; rd_addr_in = 5'd13; reg_write_in = 1'b1;
    @(negedge clk);
    check("rstb_idle_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #2;
    check("rstb_busy_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstb_req", {31'd0, dmem_req}, 32'd0);
    check("rstb_stall", {31'd0, stall}, 32'd0);
    check("rstb_wb_data", wb_data, 32'd0);
    check("rstb_rd_out", {27'd0, rd_addr_out}, 32'd0);
    check("rstb_flags", {29'd0, wb_valid, misaligned, bus_error}, 32'd0);
    drop_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstb_post_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rstb_post_req", {31'd0, dmem_req}, 32'd0);
    end
    alu_op(32'hFEED_0001, 5'd31, 1'b1);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
